jtlabrun_gfxcfg: RTL and testbench

- CPU-facing control stage of the Labyrinth Runner tile/sprite generator.
- Consumes the main CPU's gfx bus (gfx_cs, gfx_addr, cpu_rnw, cpu_dout) for the 8-byte configuration window at 0x0000-0x00FF.
- Holds the config register file and produces shadowed scroll/flip/bank controls for the video pipeline.
- Generates the gfx_irqn (vblank IRQ) and gfx_nmin (periodic line NMI) signals consumed by the main CPU.

---
 rtl/jtlabrun_gfx_pkg.sv | 18 +
 rtl/jtlabrun_nmigen.sv | 44 ++++
 rtl/jtlabrun_gfxcfg.sv | 130 +++++++++++++
 tb/tb_jtlabrun_gfxcfg.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtlabrun_gfx_pkg.sv
// Shared constants for the Labyrinth Runner gfx configuration stage:
// register indices of the 8-byte config window and reg7 control bit positions.
package jtlabrun_gfx_pkg;

  localparam logic [2:0] REG_SCRXL    = 3'd0;
  localparam logic [2:0] REG_SCRXH    = 3'd1;
  localparam logic [2:0] REG_SCRY     = 3'd2;
  localparam logic [2:0] REG_CTRL3    = 3'd3;
  localparam logic [2:0] REG_CTRL4    = 3'd4;
  localparam logic [2:0] REG_CHARBANK = 3'd5;
  localparam logic [2:0] REG_PALBANK  = 3'd6;
  localparam logic [2:0] REG_CTRL7    = 3'd7;

  localparam int CTRL7_NMIEN = 0;
  localparam int CTRL7_IRQEN = 1;
  localparam int CTRL7_FLIP  = 3;

endpackage

// File: rtl/jtlabrun_nmigen.sv
// Periodic line NMI: fires when vdump moves onto a multiple of NMI_LINES and
// holds nmin low for NMI_LEN clk cycles; a new trigger restarts the pulse.
module jtlabrun_nmigen #(
  parameter int NMI_LINES = 32,
  parameter int NMI_LEN   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nmi_en,
  input  logic [8:0] vdump,
  output logic       nmin
);

  localparam int LW = $clog2(NMI_LINES);
  localparam int CW = $clog2(NMI_LEN);

  logic [8:0]    vdump_l;
  logic [CW-1:0] cnt;
  logic          trig;

  assign trig = nmi_en && (vdump != vdump_l) && (vdump[LW-1:0] == '0);

  // vdump_l follows the line counter even in reset so leaving reset never
  // looks like a line change.
  always_ff @(posedge clk) begin
    vdump_l <= vdump;
  end

  // nmin is registered from the pre-decrement count, so the low time covers
  // the load cycle plus NMI_LEN-1 decrements: NMI_LEN cycles in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      nmin <= 1'b1;
    end else if (trig) begin
      cnt  <= CW'(NMI_LEN - 1);
      nmin <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      nmin <= (cnt == '0);
    end
  end

endmodule

// File: rtl/jtlabrun_gfxcfg.sv
// CPU-facing config register file of the Labyrinth Runner tile/sprite chip:
// scroll/flip shadowing, bank controls, vblank IRQ and the line NMI.
module jtlabrun_gfxcfg
  import jtlabrun_gfx_pkg::*;
#(
  parameter int NMI_LINES = 32,
  parameter int NMI_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        gfx_cs,
  input  logic [13:0] gfx_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cfg_dout,
  input  logic [8:0]  vdump,
  input  logic        LHBL,
  input  logic        LVBL,
  output logic [8:0]  scrx,
  output logic [7:0]  scry,
  output logic        flip,
  output logic [7:0]  ctrl3,
  output logic [7:0]  ctrl4,
  output logic [7:0]  charbank,
  output logic [7:0]  palbank,
  output logic        gfx_irqn,
  output logic        gfx_nmin
);

  logic [7:0] regs [8];
  logic       cfg_hit;
  logic       cfg_we;
  logic [2:0] idx;
  logic       lhbl_l;
  logic       lvbl_l;
  logic       lhbl_fall;
  logic       lvbl_fall;
  logic       wr7;
  logic       irqen_nx;
  logic       flip_nx;
  logic [8:0] scrx_nx;
  logic [7:0] scry_nx;
  logic       unused_bits;

  assign cfg_hit   = gfx_cs && (gfx_addr[13:8] == 6'd0);
  assign idx       = gfx_addr[2:0];
  assign cfg_we    = cpu_cen && cfg_hit && !cpu_rnw;
  assign lhbl_fall = lhbl_l && !LHBL;
  assign lvbl_fall = lvbl_l && !LVBL;
  assign wr7       = cfg_we && (idx == REG_CTRL7);

  // Values the registers will hold after this clk, so shadow loads and the
  // IRQ edge see a write landing in the same cycle.
  always_comb begin
    irqen_nx = wr7 ? cpu_dout[CTRL7_IRQEN] : regs[REG_CTRL7][CTRL7_IRQEN];
    flip_nx  = wr7 ? cpu_dout[CTRL7_FLIP]  : regs[REG_CTRL7][CTRL7_FLIP];
    scrx_nx  = {regs[REG_SCRXH][0], regs[REG_SCRXL]};
    scry_nx  = regs[REG_SCRY];
    if (cfg_we && idx == REG_SCRXL) scrx_nx[7:0] = cpu_dout;
    if (cfg_we && idx == REG_SCRXH) scrx_nx[8]   = cpu_dout[0];
    if (cfg_we && idx == REG_SCRY)  scry_nx      = cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (cfg_we) begin
      regs[idx] <= cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_dout <= 8'hff;
    end else if (cfg_hit) begin
      cfg_dout <= regs[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lhbl_l <= 1'b1;
      lvbl_l <= 1'b1;
      scrx   <= 9'd0;
      scry   <= 8'd0;
      flip   <= 1'b0;
    end else begin
      lhbl_l <= LHBL;
      lvbl_l <= LVBL;
      if (lhbl_fall) begin
        scrx <= scrx_nx;
        scry <= scry_nx;
      end
      if (lvbl_fall) flip <= flip_nx;
    end
  end

  // Writing reg7 with IRQ enable clear is the acknowledge and beats a
  // simultaneous vblank edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      gfx_irqn <= 1'b1;
    end else if (wr7 && !cpu_dout[CTRL7_IRQEN]) begin
      gfx_irqn <= 1'b1;
    end else if (lvbl_fall && irqen_nx) begin
      gfx_irqn <= 1'b0;
    end
  end

  jtlabrun_nmigen #(
    .NMI_LINES (NMI_LINES),
    .NMI_LEN   (NMI_LEN)
  ) u_nmigen (
    .clk    (clk),
    .rst    (rst),
    .nmi_en (regs[REG_CTRL7][CTRL7_NMIEN]),
    .vdump  (vdump),
    .nmin   (gfx_nmin)
  );

  assign ctrl3    = regs[REG_CTRL3];
  assign ctrl4    = regs[REG_CTRL4];
  assign charbank = regs[REG_CHARBANK];
  assign palbank  = regs[REG_PALBANK];

  assign unused_bits = ^{gfx_addr[7:3], regs[REG_SCRXH][7:1],
                         regs[REG_CTRL7][7:4], regs[REG_CTRL7][2]};

endmodule

// File: tb/tb_jtlabrun_gfxcfg.sv
// Bench for jtlabrun_gfxcfg: bus driver tasks, a reference register model,
// a read scoreboard and an NMI pulse scoreboard, then a one-line report.
module tb_jtlabrun_gfxcfg;

  localparam int NMI_LINES = 32;
  localparam int NMI_LEN   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cen = 1'b0;
  logic        gfx_cs = 1'b0;
  logic [13:0] gfx_addr = 14'd0;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_dout = 8'd0;
  logic [8:0]  vdump = 9'd0;
  logic        LHBL = 1'b1;
  logic        LVBL = 1'b1;
  logic [7:0]  cfg_dout;
  logic [8:0]  scrx;
  logic [7:0]  scry;
  logic        flip;
  logic [7:0]  ctrl3, ctrl4, charbank, palbank;
  logic        gfx_irqn, gfx_nmin;

  jtlabrun_gfxcfg #(.NMI_LINES(NMI_LINES), .NMI_LEN(NMI_LEN)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .gfx_cs(gfx_cs), .gfx_addr(gfx_addr),
    .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout), .cfg_dout(cfg_dout), .vdump(vdump),
    .LHBL(LHBL), .LVBL(LVBL), .scrx(scrx), .scry(scry), .flip(flip),
    .ctrl3(ctrl3), .ctrl4(ctrl4), .charbank(charbank), .palbank(palbank),
    .gfx_irqn(gfx_irqn), .gfx_nmin(gfx_nmin)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model and scoreboards
  logic [7:0] m_regs [8];
  logic [7:0] m_dout = 8'hff;
  logic [7:0] exp_q [$];
  int         nmi_line_q [$];
  int         nmi_w_q [$];
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic void check(string name, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_dout = 8'hff;
  endfunction

  function automatic void push_nmi(int line, int width);
    nmi_line_q.push_back(line);
    nmi_w_q.push_back(width);
  endfunction

  // read monitor: a read hit presents its data on cfg_dout one clk later
  logic rd_hit = 1'b0;
  always @(posedge clk) rd_hit <= gfx_cs && (gfx_addr[13:8] == 6'd0) && cpu_rnw && !rst;

  always @(negedge clk) begin
    if (rd_hit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL cfg_read_unexpected: got %h with no expected entry", cfg_dout);
      end else begin
        check("cfg_read", 16'(cfg_dout), 16'(exp_q.pop_front()));
      end
    end
  end

  // NMI monitor: measures each low pulse (start line and width in clks)
  int       nmi_w = 0;
  int       nmi_line = 0;
  logic     nmin_prev = 1'b1;
  always @(negedge clk) begin
    if (gfx_nmin === 1'b0) begin
      if (nmin_prev !== 1'b0) begin
        nmi_line = int'(vdump);
        nmi_w = 0;
      end
      nmi_w++;
    end else if (nmin_prev === 1'b0) begin
      if (nmi_line_q.size() == 0) begin
        n_checks++;
        $display("FAIL nmi_unexpected: pulse at line %0d width %0d, none expected", nmi_line, nmi_w);
      end else begin
        check("nmi_line", 16'(nmi_line), 16'(nmi_line_q.pop_front()));
        check("nmi_width", 16'(nmi_w), 16'(nmi_w_q.pop_front()));
      end
    end
    nmin_prev = gfx_nmin;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [13:0] a, input logic rnw, input logic [7:0] d, input logic cen);
    gfx_cs = 1'b1; gfx_addr = a; cpu_rnw = rnw; cpu_dout = d; cpu_cen = cen;
    if (a[13:8] == 6'd0) begin
      m_dout = m_regs[a[2:0]];
      if (rnw) exp_q.push_back(m_regs[a[2:0]]);
      else if (cen) m_regs[a[2:0]] = d;
    end
    tick();
    gfx_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    bus(a, 1'b0, d, 1'b1);
  endtask

  task automatic rd(input logic [13:0] a);
    bus(a, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic lvbl_fall();
    LVBL = 1'b0; tick();
    LVBL = 1'b1; tick();
  endtask

  task automatic check_ctrl();
    check("ctrl3", 16'(ctrl3), 16'(m_regs[3]));
    check("ctrl4", 16'(ctrl4), 16'(m_regs[4]));
    check("charbank", 16'(charbank), 16'(m_regs[5]));
    check("palbank", 16'(palbank), 16'(m_regs[6]));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cfg_dout"}, 16'(cfg_dout), 16'h00ff);
    check({tag, "_irqn"}, 16'(gfx_irqn), 16'd1);
    check({tag, "_nmin"}, 16'(gfx_nmin), 16'd1);
    check({tag, "_scrx"}, 16'(scrx), 16'd0);
    check({tag, "_scry"}, 16'(scry), 16'd0);
    check({tag, "_flip"}, 16'(flip), 16'd0);
    check_ctrl();
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset");

    for (int i = 0; i < 8; i++) rd(14'(i));

    // scroll writes become visible only after the LHBL fall
    wr(14'h000, 8'h34);
    wr(14'h001, 8'h01);
    wr(14'h002, 8'h5a);
    LHBL = 1'b0;
    check("scrx_before_hbl", 16'(scrx), 16'd0);
    tick();
    check("scrx_after_hbl", 16'(scrx), 16'h0134);
    check("scry_after_hbl", 16'(scry), 16'h005a);
    LHBL = 1'b1; tick();
    wr(14'h00a, 8'h77);
    rd(14'h002);

    // randomized register traffic against the model
    for (int n = 0; n < 80; n++) begin
      int op;
      logic [2:0] idx;
      logic [13:0] a;
      op  = $urandom_range(0, 4);
      idx = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) a = {6'($urandom_range(1, 63)), 5'($urandom), idx};
      else                           a = {6'd0, 5'($urandom), idx};
      case (op)
        0: bus(a, 1'b0, 8'($urandom), ($urandom_range(0, 4) != 0));
        1: bus({a[13:3], 3'($urandom_range(0, 7))}, 1'b1, 8'h00, 1'b1);
        2: begin
          LHBL = 1'b0; tick();
          check("scrx_shadow", 16'(scrx), 16'({m_regs[1][0], m_regs[0]}));
          check("scry_shadow", 16'(scry), 16'(m_regs[2]));
          LHBL = 1'b1; tick();
        end
        3: begin
          LHBL = 1'b0;
          wr(14'($urandom_range(0, 2)), 8'($urandom));
          check("scrx_same_clk", 16'(scrx), 16'({m_regs[1][0], m_regs[0]}));
          check("scry_same_clk", 16'(scry), 16'(m_regs[2]));
          LHBL = 1'b1; tick();
        end
        default: begin
          bus({6'($urandom_range(1, 63)), 8'($urandom)}, 1'b1, 8'h00, 1'b1);
          check("cfg_dout_hold", 16'(cfg_dout), 16'(m_dout));
        end
      endcase
      check_ctrl();
    end

    // flip and vblank IRQ
    wr(14'h007, 8'h08);
    check("flip_before_vbl", 16'(flip), 16'd0);
    lvbl_fall();
    check("flip_after_vbl", 16'(flip), 16'd1);
    check("irq_disabled", 16'(gfx_irqn), 16'd1);
    wr(14'h007, 8'h02);
    lvbl_fall();
    check("irq_assert", 16'(gfx_irqn), 16'd0);
    check("flip_cleared", 16'(flip), 16'd0);
    for (int f = 0; f < 3; f++) begin
      repeat (20) tick();
      lvbl_fall();
      check("irq_level", 16'(gfx_irqn), 16'd0);
    end
    wr(14'h007, 8'h00);
    check("irq_ack", 16'(gfx_irqn), 16'd1);
    lvbl_fall();
    check("irq_off_no_assert", 16'(gfx_irqn), 16'd1);
    wr(14'h007, 8'h02);
    LVBL = 1'b0; wr(14'h007, 8'h00);
    check("irq_ack_wins", 16'(gfx_irqn), 16'd1);
    LVBL = 1'b1; tick();
    LVBL = 1'b0; wr(14'h007, 8'h02);
    check("irq_new_reg7_decides", 16'(gfx_irqn), 16'd0);
    LVBL = 1'b1; tick();
    LVBL = 1'b0; wr(14'h007, 8'h02);
    check("irq_keep_asserted", 16'(gfx_irqn), 16'd0);
    LVBL = 1'b1; tick();
    wr(14'h007, 8'h00);
    check("irq_ack2", 16'(gfx_irqn), 16'd1);

    // line NMI: sweep every line, one pulse per NMI_LINES boundary
    vdump = 9'd255; tick();
    wr(14'h007, 8'h01);
    for (int v = 0; v < 256; v++) begin
      vdump = 9'(v);
      if (v % NMI_LINES == 0) push_nmi(v, NMI_LEN);
      repeat (70) tick();
    end
    check("nmi_sweep_all_seen", 16'(nmi_line_q.size()), 16'd0);
    vdump = 9'd32; push_nmi(32, NMI_LEN);
    repeat (300) tick();
    begin
      int h;
      h = $urandom_range(5, 40);
      vdump = 9'd64; push_nmi(64, h + NMI_LEN);
      repeat (h) tick();
      vdump = 9'd96;
      repeat (120) tick();
    end
    vdump = 9'd128; push_nmi(128, NMI_LEN);
    repeat (5) tick();
    wr(14'h007, 8'h00);
    repeat (80) tick();
    vdump = 9'd160;
    repeat (80) tick();
    wr(14'h007, 8'h01);
    for (int k = 0; k < 8; k++) begin
      int v;
      v = $urandom_range(0, 15) * NMI_LINES + (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, NMI_LINES - 1));
      if (v != int'(vdump) && v % NMI_LINES == 0) push_nmi(v, NMI_LEN);
      vdump = 9'(v);
      repeat (80) tick();
    end
    check("nmi_all_seen", 16'(nmi_line_q.size()), 16'd0);

    // reset in the middle of an NMI pulse with IRQ asserted
    wr(14'h007, 8'h03);
    lvbl_fall();
    check("irq_before_rst", 16'(gfx_irqn), 16'd0);
    wr(14'h000, 8'h11);
    LHBL = 1'b0; tick(); LHBL = 1'b1; tick();
    vdump = 9'd1; tick();
    vdump = 9'd192; push_nmi(192, 5);
    repeat (5) tick();
    rst = 1'b1; tick();
    model_reset();
    check_reset_outputs("midrst");
    rst = 1'b0; tick();
    for (int i = 0; i < 8; i++) rd(14'(i));

    // writes that must not land, and reads that must not update cfg_dout
    bus(14'h004, 1'b0, 8'h55, 1'b0);
    check("cen_low_write", 16'(ctrl4), 16'd0);
    wr(14'h1004, 8'h66);
    check("outside_write", 16'(ctrl4), 16'd0);
    rd(14'h004);
    wr(14'h003, 8'ha5);
    rd(14'h003);
    bus(14'h1003, 1'b1, 8'h00, 1'b1);
    check("outside_read_hold", 16'(cfg_dout), 16'h00a5);
    wr(14'h1003, 8'h5a);
    check("outside_write_ctrl3", 16'(ctrl3), 16'h00a5);

    repeat (4) tick();
    check("read_queue_empty", 16'(exp_q.size()), 16'd0);
    check("nmi_queue_empty", 16'(nmi_line_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
